pi_lane_permuter: RTL and testbench
===================================

Name: pi_lane_permuter

Overview:
- Parametrised successor to the 5x5 index-walking datapath. Operates on a 5x5 grid of LANE_W-bit lanes (addr = 5*i + j) rather than single bits.
- Accepts 25 lanes serially, applies the permutation (i,j) -> (j, (2i+3j) mod 5) ITER times using ping-pong lane buffers, then streams 25 lanes out.
- Sits between the line loader and the downstream round logic of the permutation core.

Parameters:
- LANE_W, 8, bits per lane (>=1)
- ITER, 1, permutation passes per block (1..31)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- in_valid  in  1  input lane valid
- in_ready  out  1  permuter accepts input lane
- in_data  in  LANE_W  input lane, addresses 0..24 in arrival order
- out_valid  out  1  output lane valid
- out_ready  in  1  downstream accepts output lane
- out_data  out  LANE_W  output lane, addresses 0..24 in order
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset (rst=0, asynchronous, any state including mid-operation):
  - state=IDLE; all counters cleared; buffer select=A.
  - in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
  - Buffer contents are don't-care.
- States: IDLE, LOAD, PERM, DRAIN.
- IDLE:
  - in_ready=1.
  - An accepted lane (in_valid & in_ready) writes buffer A addr 0, sets load count=1 and moves to LOAD.
- LOAD:
  - in_ready=1; each handshake writes the current buffer at load count, then increments it.
  - The 25th accept (count 24) moves to PERM with move count=0 and pass count=0.
  - in_valid low stalls with no change.
- PERM:
  - in_ready=0.
  - Each cycle reads source addr s = 5*i+j from the current buffer and writes dest addr 5*j + ((2*i+3*j) mod 5) in the other buffer.
  - i = s/5 and j = s mod 5 come from a 5-bit move counter 0..24 (no divide: i and j are separate mod-5 counters).
  - After move 24: swap buffers, increment pass count. If pass count reaches ITER, go to DRAIN; else restart at move 0.
  - Exactly 25*ITER cycles in PERM.
- DRAIN:
  - out_valid=1; out_data = current buffer[drain count], registered so it is valid in the same cycle out_valid rises.
  - Increment drain count on out_valid & out_ready.
  - out_data and out_valid stay stable while out_ready=0.
  - The 25th handshake moves to IDLE with done=1 for one cycle and buffer select reset to A.
- Latency: first out_valid is exactly 25*ITER+1 cycles after the rising edge capturing the 25th input lane.
- No overlap: input is not accepted during PERM or DRAIN.
- Widths:
  - Move, load and drain counters: 5 bits, never exceed 24.
  - Pass counter: 5 bits.
  - Mod-5 arithmetic uses at most 3-bit i/j plus a subtract-5 correction on a 4-bit sum.

Optional Feature:
- Macro: PI_LANE_PERMUTER_RHO_EN.
- When defined, each lane is rotated left by (R[s] mod LANE_W) during every PERM move, before the write. R is indexed by source s = 5*i+j:
  - i=0: 0,36,3,41,18
  - i=1: 1,44,10,45,2
  - i=2: 62,6,43,15,61
  - i=3: 28,55,25,21,56
  - i=4: 27,20,39,8,14
- When undefined, lanes move unrotated and no rotation logic is synthesised.
- Timing is identical in both builds.

Test Plan:
- Basic permutation (LANE_W=8, ITER=1): load lane k = k for k=0..24, out_ready=1. Expect first out_valid 26 cycles after the last accept, out[0]=0, out[8]=1, out[2]=5, all 25 outputs a permutation of 0..24, and done pulses once.
- Identity cycle (ITER=24): load lane k = k. Expect out[k]=k for all k, since the map has order 24; busy stays high throughout.
- Backpressure: hold out_ready=0 for 10 cycles at drain count 3, then release. Expect out_data stable at the count-3 value and no lanes skipped or duplicated.
- Input stalls: drop in_valid for 5 cycles after 12 lanes. Expect no state change; PERM starts only after 25 total accepts, and in_ready=0 from PERM until IDLE.
- Reset mid-PERM: assert rst=0 at move 10 of pass 0. Expect all outputs immediately 0 and state IDLE. A fresh load then produces correct results.
- RHO_EN build (LANE_W=8, ITER=1): all lanes 0x01. Expect out[0]=0x01; out[8]=0x10 (source 1, 36 mod 8 = 4); out[2]=0x02 (source 5, rotate 1).

Source files
------------

// File: rtl/pi_lane_permuter.sv
// Serial 25-lane loader, ITER-pass pi lane permutation over ping-pong buffers, serial drain.
// Optional per-lane rotation during each move when PI_LANE_PERMUTER_RHO_EN is defined.
module pi_lane_permuter #(
   parameter int unsigned LANE_W = 8,
   parameter int unsigned ITER   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LANE_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {StIdle, StLoad, StPerm, StDrain} state_e;

   localparam logic [4:0] LastIdx  = 5'd24;
   localparam logic [4:0] LastPass = 5'(ITER - 1);

   function automatic logic [2:0] mod5Fix(input logic [3:0] x);
      return (x >= 4'd5) ? 3'(x - 4'd5) : x[2:0];
   endfunction

   state_e             stateQ, stateD;
   logic [4:0]         loadCntQ, loadCntD;
   logic [4:0]         moveCntQ, moveCntD;
   logic [2:0]         iQ, iD, jQ, jD;
   logic [4:0]         passQ, passD;
   logic [4:0]         drainQ, drainD;
   logic               selQ, selD;
   logic               outValidQ, outValidD;
   logic [LANE_W-1:0]  outDataQ, outDataD;
   logic               doneQ, doneD;

   logic [LANE_W-1:0]  bufA [25];
   logic [LANE_W-1:0]  bufB [25];

   logic [4:0]         rdAddr;
   logic [LANE_W-1:0]  rdLane, permLane;
   logic [2:0]         twoI, twoJ, threeJ, rowOut;
   logic [4:0]         destAddr;
   logic               wrEn, wrToB;
   logic [4:0]         wrAddr;
   logic [LANE_W-1:0]  wrData;

   // Destination column (2i+3j) mod 5 built from small mod-5 corrections
   assign twoI     = mod5Fix({iQ, 1'b0});
   assign twoJ     = mod5Fix({jQ, 1'b0});
   assign threeJ   = mod5Fix({1'b0, twoJ} + {1'b0, jQ});
   assign rowOut   = mod5Fix({1'b0, twoI} + {1'b0, threeJ});
   assign destAddr = {jQ, 2'b00} + {2'b00, jQ} + {2'b00, rowOut};

   always_comb begin
      rdAddr = moveCntQ;
      // Drain prefetches the next lane so out_data is registered with out_valid
      if (stateQ == StDrain) rdAddr = outValidQ ? drainQ + 5'd1 : drainQ;
   end

   assign rdLane = selQ ? bufB[rdAddr] : bufA[rdAddr];

`ifdef PI_LANE_PERMUTER_RHO_EN
   localparam int unsigned RhoTab [25] = '{
      0, 36, 3, 41, 18,
      1, 44, 10, 45, 2,
      62, 6, 43, 15, 61,
      28, 55, 25, 21, 56,
      27, 20, 39, 8, 14
   };
   logic [2*LANE_W-1:0] rotWide;
   always_comb begin
      rotWide  = {rdLane, rdLane} << (RhoTab[moveCntQ] % LANE_W);
      permLane = rotWide[2*LANE_W-1:LANE_W];
   end
`else
   assign permLane = rdLane;
`endif

   always_comb begin
      stateD    = stateQ;
      loadCntD  = loadCntQ;
      moveCntD  = moveCntQ;
      iD        = iQ;
      jD        = jQ;
      passD     = passQ;
      drainD    = drainQ;
      selD      = selQ;
      outValidD = outValidQ;
      outDataD  = outDataQ;
      doneD     = 1'b0;
      wrEn      = 1'b0;
      wrToB     = 1'b0;
      wrAddr    = '0;
      wrData    = '0;
      unique case (stateQ)
         StIdle: begin
            if (in_valid) begin
               wrEn     = 1'b1;
               wrData   = in_data;
               loadCntD = 5'd1;
               stateD   = StLoad;
            end
         end
         StLoad: begin
            if (in_valid) begin
               wrEn   = 1'b1;
               wrToB  = selQ;
               wrAddr = loadCntQ;
               wrData = in_data;
               if (loadCntQ == LastIdx) begin
                  loadCntD = '0;
                  moveCntD = '0;
                  iD       = '0;
                  jD       = '0;
                  passD    = '0;
                  stateD   = StPerm;
               end else begin
                  loadCntD = loadCntQ + 5'd1;
               end
            end
         end
         StPerm: begin
            wrEn   = 1'b1;
            wrToB  = ~selQ;
            wrAddr = destAddr;
            wrData = permLane;
            if (moveCntQ == LastIdx) begin
               moveCntD = '0;
               iD       = '0;
               jD       = '0;
               selD     = ~selQ;
               passD    = passQ + 5'd1;
               if (passQ == LastPass) begin
                  drainD = '0;
                  stateD = StDrain;
               end
            end else begin
               moveCntD = moveCntQ + 5'd1;
               if (jQ == 3'd4) begin
                  jD = '0;
                  iD = iQ + 3'd1;
               end else begin
                  jD = jQ + 3'd1;
               end
            end
         end
         StDrain: begin
            if (!outValidQ) begin
               outValidD = 1'b1;
               outDataD  = rdLane;
            end else if (out_ready) begin
               if (drainQ == LastIdx) begin
                  outValidD = 1'b0;
                  outDataD  = '0;
                  drainD    = '0;
                  passD     = '0;
                  selD      = 1'b0;
                  doneD     = 1'b1;
                  stateD    = StIdle;
               end else begin
                  drainD   = drainQ + 5'd1;
                  outDataD = rdLane;
               end
            end
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ    <= StIdle;
         loadCntQ  <= '0;
         moveCntQ  <= '0;
         iQ        <= '0;
         jQ        <= '0;
         passQ     <= '0;
         drainQ    <= '0;
         selQ      <= 1'b0;
         outValidQ <= 1'b0;
         outDataQ  <= '0;
         doneQ     <= 1'b0;
      end else begin
         stateQ    <= stateD;
         loadCntQ  <= loadCntD;
         moveCntQ  <= moveCntD;
         iQ        <= iD;
         jQ        <= jD;
         passQ     <= passD;
         drainQ    <= drainD;
         selQ      <= selD;
         outValidQ <= outValidD;
         outDataQ  <= outDataD;
         doneQ     <= doneD;
      end
   end

   // Lane storage needs no reset; contents are rewritten by every load
   always_ff @(posedge clk) begin
      if (wrEn) begin
         if (wrToB) bufB[wrAddr] <= wrData;
         else       bufA[wrAddr] <= wrData;
      end
   end

   assign in_ready  = rst & ((stateQ == StIdle) | (stateQ == StLoad));
   assign out_valid = outValidQ;
   assign out_data  = outDataQ;
   assign busy      = (stateQ != StIdle);
   assign done      = doneQ;

endmodule

// File: tb/tb_pi_lane_permuter.sv
// Bench for pi_lane_permuter: directed sequence with random lane data checked against a
// behavioural permutation model; follows PI_LANE_PERMUTER_RHO_EN when defined.
module tb_pi_lane_permuter;

   typedef logic [7:0] blk_t [25];

   logic clk = 1'b0;
   logic rst;
   logic inValid, inReady, inReadyB;
   logic [7:0] inData;
   logic outValid, outReady, outValidB;
   logic [7:0] outData, outDataB;
   logic busy, done, busyB, doneB;
   logic bEn;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int doneCnt = 0;
   int doneCntB = 0;
   int readyBad, stableBad, stallBad;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (done) doneCnt <= doneCnt + 1;
   always @(posedge clk) if (doneB) doneCntB <= doneCntB + 1;

   pi_lane_permuter #(.LANE_W(8), .ITER(1)) dutA (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady), .in_data(inData),
      .out_valid(outValid), .out_ready(outReady), .out_data(outData),
      .busy(busy), .done(done)
   );

   pi_lane_permuter #(.LANE_W(8), .ITER(24)) dutB (
      .clk(clk), .rst(rst), .in_valid(inValid & bEn), .in_ready(inReadyB), .in_data(inData),
      .out_valid(outValidB), .out_ready(1'b1), .out_data(outDataB),
      .busy(busyB), .done(doneB)
   );

`ifdef PI_LANE_PERMUTER_RHO_EN
   int unsigned rhoR [25] = '{0, 36, 3, 41, 18, 1, 44, 10, 45, 2, 62, 6, 43, 15, 61,
                              28, 55, 25, 21, 56, 27, 20, 39, 8, 14};
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int a);
      return (x << a) | (x >> (8 - a));
   endfunction

   // Position (i,j) moves to (j, (2i+3j) mod 5), applied iters times
   function automatic void model(input blk_t d, input int iters, output blk_t q);
      blk_t cur, nxt;
      cur = d;
      for (int p = 0; p < iters; p++) begin
         for (int s = 0; s < 25; s++) begin
            int i, j, amt;
            i = s / 5;
            j = s % 5;
            amt = 0;
`ifdef PI_LANE_PERMUTER_RHO_EN
            amt = int'(rhoR[s] % 8);
`endif
            nxt[5 * j + (2 * i + 3 * j) % 5] = rotl8(cur[s], amt);
         end
         cur = nxt;
      end
      q = cur;
   endfunction

   task automatic loadBlock(input blk_t d, input int stallAfter, output int accCyc);
      int k, stall, guard;
      bit acc;
      k = 0; stall = 0; guard = 0;
      while (k < 25 && guard < 300) begin
         @(negedge clk);
         guard++;
         if (k == stallAfter && stall < 5) begin
            inValid = 1'b0;
            stall++;
            acc = 1'b0;
            if (!inReady || !busy || outValid) stallBad++;
         end else begin
            inValid = 1'b1;
            inData = d[k];
            acc = inReady;
         end
         @(posedge clk);
         if (acc) k++;
      end
      @(negedge clk);
      inValid = 1'b0;
      accCyc = cyc;
      check("load_count", k, 25);
   endtask

   task automatic drainBlock(input int bpAt, output blk_t got, output int firstCyc);
      int n, bp, guard, d0;
      logic [7:0] holdVal;
      n = 0; bp = 0; guard = 0; firstCyc = -1; holdVal = '0;
      d0 = doneCnt;
      outReady = 1'b1;
      while (n < 25 && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (inReady) readyBad++;
         if (outValid) begin
            if (firstCyc < 0) firstCyc = cyc;
            if (n == bpAt && bp < 10) begin
               if (bp == 0) holdVal = outData;
               else if (outData !== holdVal) stableBad++;
               outReady = 1'b0;
               bp++;
            end else begin
               if (n == bpAt && outData !== holdVal) stableBad++;
               outReady = 1'b1;
               got[n] = outData;
               n++;
            end
         end
      end
      check("drain_count", n, 25);
      @(negedge clk);
      check("done_pulse_hi", {31'b0, done}, 1);
      check("valid_drop", {31'b0, outValid}, 0);
      @(negedge clk);
      check("done_pulse_lo", {31'b0, done}, 0);
      check("idle_ready", {30'b0, inReady, busy}, 32'h2);
      check("done_count", doneCnt - d0, 1);
   endtask

   task automatic compareBlock(input string tag, input blk_t got, input blk_t exp);
      for (int k = 0; k < 25; k++) check($sformatf("%s_out%0d", tag, k), {24'b0, got[k]},
                                         {24'b0, exp[k]});
   endtask

   initial begin
      blk_t d, q, got, gotB;
      int accCyc, firstCyc, firstB, guard, nB, busyBad;
      logic [24:0] seen;

      rst = 1'b1; inValid = 1'b0; inData = '0; outReady = 1'b0; bEn = 1'b0;
      readyBad = 0; stableBad = 0; stallBad = 0;
      #2 rst = 1'b0;
      #1;
      check("rst_outputs", {inReady, outValid, busy, done, 24'b0, outData}, 0);
      repeat (2) @(negedge clk);
      check("rst_hold", {inReady, outValid, busy, done, 24'b0, outData}, 0);
      rst = 1'b1;
      #1 check("idle_after_rst", {30'b0, inReady, busy}, 32'h2);

      // Block 1: identity data into both DUTs
      for (int k = 0; k < 25; k++) d[k] = 8'(k);
      bEn = 1'b1;
      loadBlock(d, -1, accCyc);
      bEn = 1'b0;
      drainBlock(-1, got, firstCyc);
      check("latency_iter1", firstCyc - accCyc, 26);
      model(d, 1, q);
      compareBlock("basic", got, q);
`ifndef PI_LANE_PERMUTER_RHO_EN
      check("basic_out0", {24'b0, got[0]}, 0);
      check("basic_out8", {24'b0, got[8]}, 1);
      check("basic_out2", {24'b0, got[2]}, 5);
      seen = '0;
      for (int k = 0; k < 25; k++) if (got[k] < 25) seen[got[k]] = 1'b1;
      check("basic_is_perm", {7'b0, seen}, 32'h1ffffff);
`endif

      // ITER=24 instance: busy must hold until its drain completes
      nB = 0; guard = 0; busyBad = 0; firstB = -1;
      while (nB < 25 && guard < 2000) begin
         @(negedge clk);
         guard++;
         if (!busyB) busyBad++;
         if (outValidB) begin
            if (firstB < 0) firstB = cyc;
            gotB[nB] = outDataB;
            nB++;
         end
      end
      check("iter24_count", nB, 25);
      check("iter24_latency", firstB - accCyc, 601);
      check("iter24_busy", busyBad, 0);
      model(d, 24, q);
      compareBlock("iter24", gotB, q);
`ifndef PI_LANE_PERMUTER_RHO_EN
      for (int k = 0; k < 25; k++) check($sformatf("identity%0d", k), {24'b0, gotB[k]}, k);
`endif
      repeat (2) @(negedge clk);
      check("iter24_done", doneCntB, 1);

      // Backpressure at drain count 3
      for (int k = 0; k < 25; k++) d[k] = 8'($urandom);
      loadBlock(d, -1, accCyc);
      drainBlock(3, got, firstCyc);
      model(d, 1, q);
      compareBlock("bp", got, q);
      check("bp_stable", stableBad, 0);

      // Input stall after 12 lanes
      for (int k = 0; k < 25; k++) d[k] = 8'($urandom);
      loadBlock(d, 12, accCyc);
      check("stall_state", stallBad, 0);
      check("perm_no_ready", {30'b0, inReady, busy}, 32'h1);
      drainBlock(-1, got, firstCyc);
      check("stall_latency", firstCyc - accCyc, 26);
      model(d, 1, q);
      compareBlock("stall", got, q);
      check("no_ready_perm_drain", readyBad, 0);

      // Reset at move 10 of pass 0, then a fresh block
      for (int k = 0; k < 25; k++) d[k] = 8'($urandom);
      loadBlock(d, -1, accCyc);
      repeat (10) @(negedge clk);
      check("pre_rst_busy", {31'b0, busy}, 1);
      rst = 1'b0;
      #1 check("midperm_rst", {inReady, outValid, busy, done, 24'b0, outData}, 0);
      @(negedge clk);
      rst = 1'b1;
      #1 check("rst_idle", {30'b0, inReady, busy}, 32'h2);
      for (int k = 0; k < 25; k++) d[k] = 8'($urandom);
      loadBlock(d, -1, accCyc);
      drainBlock(-1, got, firstCyc);
      model(d, 1, q);
      compareBlock("post_rst", got, q);

`ifdef PI_LANE_PERMUTER_RHO_EN
      for (int k = 0; k < 25; k++) d[k] = 8'h01;
      loadBlock(d, -1, accCyc);
      drainBlock(-1, got, firstCyc);
      check("rho_out0", {24'b0, got[0]}, 32'h01);
      check("rho_out8", {24'b0, got[8]}, 32'h10);
      check("rho_out2", {24'b0, got[2]}, 32'h02);
      model(d, 1, q);
      compareBlock("rho", got, q);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
